// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder and slave response mux, with a built-in default slave that
// answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR and counts them.
module ahblite_decoder_mux #(
  parameter int unsigned         NPORT     = 5,
  parameter logic [NPORT-1:0]    PORT_EN   = '1,
  parameter logic [NPORT*32-1:0] BASE_ADDR = {32'h4000_0020, 32'h2000_0000, 32'h0000_0000,
                                              32'h4000_0000, 32'h4000_0010},
  parameter logic [NPORT*32-1:0] ADDR_MASK = {32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_0000,
                                              32'hFFFF_FFF0, 32'hFFFF_FFF0}
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NPORT-1:0]      HSEL_P,
  input  logic [NPORT*32-1:0]   HRDATA_P,
  input  logic [NPORT-1:0]      HREADYOUT_P,
  input  logic [NPORT-1:0]      HRESP_P,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  input  logic                  ERR_CNT_CLR,
  output logic [15:0]           ERR_CNT
);

  localparam logic [1:0] StOk   = 2'd0;
  localparam logic [1:0] StErr1 = 2'd1;
  localparam logic [1:0] StErr2 = 2'd2;

  logic             hit;
  logic [2:0]       hit_idx;
  logic [NPORT-1:0] hsel;
  logic             sel_def_q;
  logic [2:0]       sel_idx_q;
  logic [1:0]       state_q, state_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  // Lowest matching index wins, so HSEL_P is one-hot or zero.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hsel    = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (!hit && PORT_EN[i] &&
          ((HADDR & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
        hsel[i] = 1'b1;
      end
    end
  end

  assign HSEL_P  = hsel;
  assign ERR_CNT = err_cnt_q;

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (sel_def_q) begin
      HREADY = (state_q != StErr1);
      HRESP  = (state_q != StOk);
    end else begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (sel_idx_q == 3'(i)) begin
          HRDATA = HRDATA_P[32*i +: 32];
          HREADY = HREADYOUT_P[i];
          HRESP  = HRESP_P[i];
        end
      end
    end
  end

  // ERR1 always advances; from OK or ERR2 a new unmapped NONSEQ/SEQ starts another error.
  always_comb begin
    state_d = StOk;
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (HREADY && !hit && HTRANS[1]) begin
      state_d = StErr1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ERR_CNT_CLR) begin
      err_cnt_d = '0;
    end else if (state_d == StErr1 && state_q != StErr1 && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_def_q <= 1'b1;
      sel_idx_q <= '0;
      state_q   <= StOk;
      err_cnt_q <= '0;
    end else begin
      if (HREADY) begin
        sel_def_q <= !hit;
        sel_idx_q <= hit_idx;
      end
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Randomized plus directed bench for ahblite_decoder_mux; two instances (all ports enabled,
// port 0 disabled) are checked every cycle against a transaction-level reference model.
module tb_ahblite_decoder_mux;

  localparam int NP = 5;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10;
  localparam logic [NP-1:0] ALL = '1;
  localparam logic [31:0] BASE [NP] = '{32'h4000_0010, 32'h4000_0000, 32'h0000_0000,
                                       32'h2000_0000, 32'h4000_0020};
  localparam logic [31:0] MASK [NP] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000,
                                       32'hFFFF_0000, 32'hFFFF_FFF0};

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [31:0]      HADDR = '0;
  logic [1:0]       HTRANS = IDLE;
  logic [NP*32-1:0] HRDATA_P = '0;
  logic [NP-1:0]    HREADYOUT_P = '1;
  logic [NP-1:0]    HRESP_P = '0;
  logic             ERR_CNT_CLR = 1'b0;

  logic [NP-1:0] hsel_o [2];
  logic [31:0]   hrdata_o [2];
  logic          hready_o [2];
  logic          hresp_o [2];
  logic [15:0]   err_cnt_o [2];

  logic [NP-1:0] en_k [2] = '{5'b11111, 5'b11110};

  // Model: selected port of the data phase (-1 = default slave), remaining ERROR beats, count.
  int m_sel [2];
  int m_left [2];
  int m_cnt [2];
  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahblite_decoder_mux u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL_P(hsel_o[0]),
    .HRDATA_P(HRDATA_P), .HREADYOUT_P(HREADYOUT_P), .HRESP_P(HRESP_P), .HRDATA(hrdata_o[0]),
    .HREADY(hready_o[0]), .HRESP(hresp_o[0]), .ERR_CNT_CLR(ERR_CNT_CLR), .ERR_CNT(err_cnt_o[0])
  );

  ahblite_decoder_mux #(.PORT_EN(5'b11110)) u_dut_en (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL_P(hsel_o[1]),
    .HRDATA_P(HRDATA_P), .HREADYOUT_P(HREADYOUT_P), .HRESP_P(HRESP_P), .HRDATA(hrdata_o[1]),
    .HREADY(hready_o[1]), .HRESP(hresp_o[1]), .ERR_CNT_CLR(ERR_CNT_CLR), .ERR_CNT(err_cnt_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a, input logic [NP-1:0] en);
    for (int i = 0; i < NP; i++) begin
      if (en[i] && ((a & MASK[i]) == BASE[i])) return i;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] onehot(input int idx);
    logic [NP-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return 32'h4000_0010 | ($urandom() & 32'h1F);
      1:       return 32'h4000_0000 | ($urandom() & 32'h3F);
      2:       return 32'h0000_0000 | ($urandom() & 32'hFFFF);
      3:       return 32'h2000_0000 | ($urandom() & 32'h1_FFFF);
      4:       return 32'h5000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [NP-1:0] rdy,
                      input logic [NP-1:0] rsp, input logic clr);
    int          d [2];
    logic        e_ready [2];
    logic        e_resp [2];
    logic [31:0] e_rdata [2];
    @(negedge HCLK);
    HADDR = a;
    HTRANS = t;
    HREADYOUT_P = rdy;
    HRESP_P = rsp;
    ERR_CNT_CLR = clr;
    for (int i = 0; i < NP; i++) HRDATA_P[32*i +: 32] = $urandom();
    #1;
    for (int k = 0; k < 2; k++) begin
      d[k] = decode(a, en_k[k]);
      if (m_sel[k] < 0) begin
        e_rdata[k] = '0;
        e_ready[k] = (m_left[k] != 2);
        e_resp[k]  = (m_left[k] != 0);
      end else begin
        e_rdata[k] = HRDATA_P[32*m_sel[k] +: 32];
        e_ready[k] = rdy[m_sel[k]];
        e_resp[k]  = rsp[m_sel[k]];
      end
      check($sformatf("hsel%0d", k), 32'(hsel_o[k]), 32'(onehot(d[k])));
      check($sformatf("hrdata%0d", k), hrdata_o[k], e_rdata[k]);
      check($sformatf("hready%0d", k), 32'(hready_o[k]), 32'(e_ready[k]));
      check($sformatf("hresp%0d", k), 32'(hresp_o[k]), 32'(e_resp[k]));
      check($sformatf("err_cnt%0d", k), 32'(err_cnt_o[k]), 32'(m_cnt[k]));
    end
    @(posedge HCLK);
    for (int k = 0; k < 2; k++) begin
      int nl;
      if (m_left[k] == 2) nl = 1;
      else if (e_ready[k] && d[k] < 0 && t[1]) nl = 2;
      else nl = 0;
      if (clr) m_cnt[k] = 0;
      else if (nl == 2 && m_cnt[k] < 65535) m_cnt[k]++;
      if (e_ready[k]) m_sel[k] = d[k];
      m_left[k] = nl;
    end
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESET = 1'b1;
    HTRANS = IDLE;
    ERR_CNT_CLR = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = -1;
      m_left[k] = 0;
      m_cnt[k] = 0;
      check($sformatf("rst_hready%0d", k), 32'(hready_o[k]), 32'd1);
      check($sformatf("rst_hresp%0d", k), 32'(hresp_o[k]), 32'd0);
      check($sformatf("rst_hrdata%0d", k), hrdata_o[k], 32'd0);
      check($sformatf("rst_cnt%0d", k), 32'(err_cnt_o[k]), 32'd0);
    end
    HADDR = 32'h2000_0004;
    #1;
    check("rst_hsel", 32'(hsel_o[0]), 32'h08);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    for (int k = 0; k < 2; k++) m_sel[k] = decode(HADDR, en_k[k]);
  endtask

  initial begin
    HRESET = 1'b1;
    do_reset();

    step(32'h4000_0014, NSEQ, ALL, '0, 1'b0);
    check("ex_port0", 32'(hsel_o[0]), 32'h01);
    step(32'h2000_1000, NSEQ, ALL, '0, 1'b0);
    check("ex_port3", 32'(hsel_o[0]), 32'h08);
    step(32'h4000_0028, NSEQ, ALL, '0, 1'b0);
    check("ex_port4", 32'(hsel_o[0]), 32'h10);

    // Single unmapped NONSEQ: ERROR over two cycles, then OKAY.
    step(32'h5000_0000, NSEQ, ALL, '0, 1'b0);
    check("unmapped_hsel", 32'(hsel_o[0]), 32'h00);
    repeat (3) step(32'h0000_0000, IDLE, ALL, '0, 1'b0);
    #1 check("err_cnt_one", 32'(err_cnt_o[0]), 32'd1);

    // Port 3 stalls three cycles while the address bus already points at port 0.
    step(32'h2000_1000, NSEQ, ALL, '0, 1'b0);
    repeat (3) step(32'h4000_0014, NSEQ, 5'b10111, '0, 1'b0);
    step(32'h4000_0014, NSEQ, ALL, 5'b01000, 1'b0);
    step(32'h0000_0000, IDLE, ALL, 5'b00001, 1'b0);

    // Unmapped IDLE/BUSY are OKAY; back-to-back unmapped NONSEQs count twice.
    step(32'h5000_0000, IDLE, ALL, '0, 1'b0);
    step(32'h5000_0000, BUSY, ALL, '0, 1'b0);
    repeat (4) step(32'h5000_0000, NSEQ, ALL, '0, 1'b0);
    repeat (2) step(32'h0000_0000, IDLE, ALL, '0, 1'b0);
    #1 check("err_cnt_three", 32'(err_cnt_o[0]), 32'd3);

    // Reset in the middle of an ERROR response.
    step(32'h5000_0000, NSEQ, ALL, '0, 1'b0);
    do_reset();
    step(32'h0000_0000, IDLE, ALL, '0, 1'b0);

    // Port 0 disabled on the second instance: its window becomes an error there.
    step(32'h4000_0010, NSEQ, ALL, '0, 1'b0);
    repeat (2) step(32'h0000_0000, IDLE, ALL, '0, 1'b0);
    #1 check("en_err_cnt", 32'(err_cnt_o[1]), 32'd1);

    // Saturation and clear-beats-increment.
    step(32'h0000_0000, IDLE, ALL, '0, 1'b0);
    #2;
    u_dut.err_cnt_q = 16'hFFFF;
    u_dut_en.err_cnt_q = 16'hFFFF;
    m_cnt[0] = 65535;
    m_cnt[1] = 65535;
    step(32'h5000_0000, NSEQ, ALL, '0, 1'b0);
    repeat (2) step(32'h0000_0000, IDLE, ALL, '0, 1'b0);
    #1 check("sat_cnt", 32'(err_cnt_o[0]), 32'hFFFF);
    step(32'h5000_0000, NSEQ, ALL, '0, 1'b1);
    #1 check("clr_wins", 32'(err_cnt_o[0]), 32'd0);
    repeat (2) step(32'h0000_0000, IDLE, ALL, '0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      logic [NP-1:0] rdy, rsp;
      rdy = ($urandom_range(0, 3) == 0) ? NP'($urandom()) : ALL;
      rsp = ($urandom_range(0, 7) == 0) ? NP'($urandom()) : '0;
      step(rand_addr(), 2'($urandom()), rdy, rsp, $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahblite_decoder_mux.md
AHBLITE_DECODER_MUX -- requirements
Module: ahblite_decoder_mux

Interface
REQ-001 SHALL have parameter NPORT, default 5, number of slave ports (legal 1..8).
REQ-002 SHALL have parameter PORT_EN [NPORT-1:0], default all ones; bit i=0 forces HSEL_P[i]=0 and port i never matches.
REQ-003 SHALL have parameter BASE_ADDR [NPORT*32-1:0], default {0x40000020,0x20000000,0x00000000,0x40000000,0x40000010}, port 4 down to port 0.
REQ-004 SHALL have parameter ADDR_MASK [NPORT*32-1:0], default {0xFFFFFFF0,0xFFFF0000,0xFFFF0000,0xFFFFFFF0,0xFFFFFFF0}, port 4 down to port 0.
REQ-005 SHALL have port HCLK, input, 1: bus clock; all state updates on its rising edge.
REQ-006 SHALL have port HRESET, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port HADDR, input, 32: address-phase address.
REQ-008 SHALL have port HTRANS, input, 2: transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-009 SHALL have port HSEL_P, output, NPORT: per-port select, address phase.
REQ-010 SHALL have port HRDATA_P, input, NPORT*32: slave read data, port i at [32i+31:32i].
REQ-011 SHALL have port HREADYOUT_P, input, NPORT: slave ready.
REQ-012 SHALL have port HRESP_P, input, NPORT: slave response (1=ERROR).
REQ-013 SHALL have port HRDATA, output, 32: muxed read data to master.
REQ-014 SHALL have port HREADY, output, 1: muxed ready, also fed to all slaves.
REQ-015 SHALL have port HRESP, output, 1: muxed response.
REQ-016 SHALL have port ERR_CNT_CLR, input, 1: synchronous clear of the error counter.
REQ-017 SHALL have port ERR_CNT, output, 16: saturating decode-error count.

Function
REQ-018 Port i SHALL match when PORT_EN[i]=1 and (HADDR & ADDR_MASK_i) == BASE_ADDR_i.
REQ-019 Overlaps SHALL resolve to the lowest matching index; HSEL_P SHALL be one-hot or all-zero.
REQ-020 HSEL_P SHALL be combinational from HADDR only, independent of HTRANS and HREADY.
REQ-021 No match SHALL select the internal default slave.
REQ-022 Data-phase select register SEL_D SHALL load {port index, or default} at each rising edge where HREADY=1; it SHALL hold when HREADY=0.
REQ-023 If SEL_D = port i: HRDATA=HRDATA_P[i], HREADY=HREADYOUT_P[i], HRESP=HRESP_P[i], combinationally, zero added latency.
REQ-024 If SEL_D = default slave: HRDATA=0, with HREADY and HRESP from the FSM.
REQ-025 Default-slave FSM states SHALL be OK, ERR1 and ERR2.
REQ-026 OK to ERR1 SHALL occur when HREADY=1 and there is no match and HTRANS is NONSEQ or SEQ.
REQ-027 ERR1 to ERR2 SHALL be unconditional; ERR2 to ERR1 SHALL occur on a new unmapped NONSEQ/SEQ; otherwise ERR2 returns to OK.
REQ-028 FSM outputs SHALL be: OK gives HREADY=1, HRESP=0; ERR1 gives HREADY=0, HRESP=1; ERR2 gives HREADY=1, HRESP=1 (two-cycle AHB ERROR).
REQ-029 An unmapped IDLE or BUSY SHALL receive a zero-wait OKAY and SHALL NOT increment ERR_CNT.
REQ-030 ERR_CNT SHALL increment by 1 on each FSM entry to ERR1 and saturate at 0xFFFF.
REQ-031 When ERR_CNT_CLR=1 coincides with an increment, clear SHALL win and ERR_CNT SHALL be 0.
REQ-032 Slave HRESP_P errors SHALL pass through and SHALL NOT count.

Reset
REQ-033 During HRESET=1: SEL_D=default, FSM=OK, ERR_CNT=0, so HREADY=1, HRESP=0, HRDATA=0 immediately (asynchronous).
REQ-034 HRESET asserted mid-ERR1/ERR2 SHALL abort the error response; the first cycle after release SHALL be OK.
REQ-035 HSEL_P SHALL remain a pure function of HADDR during reset.

Verification
REQ-036 Defaults: NONSEQ to 0x40000014 -> HSEL_P=00001; read 0x20001000 -> HSEL_P=01000; 0x40000028 -> 10000.
REQ-037 NONSEQ 0x50000000 -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OK; ERR_CNT=1.
REQ-038 Port 3 HREADYOUT_P low 3 cycles -> HREADY low 3 cycles; SEL_D held; a new HADDR matching port 0 meanwhile does not change HRDATA source.
REQ-039 IDLE to 0x50000000 -> HREADY=1, HRESP=0, ERR_CNT unchanged; back-to-back unmapped NONSEQs -> ERR1,ERR2,ERR1,ERR2, ERR_CNT=2.
REQ-040 ERR_CNT preloaded to 0xFFFF -> unmapped NONSEQ leaves 0xFFFF; ERR_CNT_CLR on the ERR1 entry cycle -> 0.
REQ-041 PORT_EN=11110 -> 0x40000010 unmapped, ERROR response; HRESET pulse during ERR1 -> HREADY=1, HRESP=0 asynchronously.
